// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master with configurable word width, SCLK divider, CPOL/CPHA and chip selects.
// One command per transfer; the received word is returned with a single-cycle rx_valid strobe.
module spi_master_cfg #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned NUM_CS  = 1,
    parameter int unsigned CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   tx_cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              lead_q, lead_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [NUM_CS-1:0] cs_dec;
    logic              accept, div_wrap, edge_en, last_edge, sample_en, drive_en;

    assign accept    = (state_q == StIdle) && tx_valid;
    assign div_wrap  = (div_q == DIV_LAST);
    assign edge_en   = (state_q == StXfer) && div_wrap;
    // lead_q marks that the coming SCLK edge is a leading one
    assign last_edge = edge_en && !lead_q && (bit_q == BIT_LAST);
    assign sample_en = edge_en && (lead_q ^ cpha_q);
    assign drive_en  = edge_en && (cpha_q ? lead_q : (!lead_q && !last_edge));

    // Out-of-range selects match no line, so every cs_n stays high
    always_comb begin
        cs_dec = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (32'(tx_cs_sel) != i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)    state_d = StSetup;
            StSetup: if (div_wrap)  state_d = StXfer;
            StXfer:  if (last_edge) state_d = StHold;
            StHold:  if (div_wrap)  state_d = StIdle;
        endcase
    end

    always_comb begin
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lead_d     = lead_q;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        div_d      = (state_q == StIdle || div_wrap) ? '0 : div_q + DIV_W'(1);
        unique case (state_q)
            StIdle: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                cs_n_d = '1;
                if (accept) begin
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lead_d  = 1'b1;
                    bit_d   = '0;
                    rx_sr_d = '0;
                    cs_n_d  = cs_dec;
                    // CPHA=0 presents the MSB during setup, so it leaves the shifter now
                    tx_sr_d = cpha ? tx_data : {tx_data[DATA_W-2:0], 1'b0};
                    mosi_d  = cpha ? 1'b0 : tx_data[DATA_W-1];
                end
            end
            StSetup: begin
                sclk_d = cpol_q;
            end
            StXfer: begin
                if (edge_en) begin
                    sclk_d = ~sclk_q;
                    lead_d = ~lead_q;
                    if (!lead_q) bit_d = bit_q + BIT_W'(1);
                end
                if (sample_en) rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
                if (drive_en) begin
                    mosi_d  = tx_sr_q[DATA_W-1];
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                end
            end
            StHold: begin
                sclk_d = cpol_q;
                if (div_wrap) begin
                    cs_n_d     = '1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            bit_q      <= '0;
            lead_q     <= 1'b1;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
        end else begin
            div_q      <= div_d;
            bit_q      <= bit_d;
            lead_q     <= lead_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign tx_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: an 8-bit/div-4/4-CS instance and a 16-bit/div-1 instance.
module tb_spi_master_cfg;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic       a_tx_valid, a_tx_ready, a_cpol, a_cpha, a_rx_valid, a_busy, a_sclk, a_mosi;
    logic       a_loop;
    logic       a_miso;
    logic [7:0] a_tx_data, a_rx_data;
    logic [2:0] a_sel;
    logic [3:0] a_cs_n;

    logic        b_tx_valid, b_tx_ready, b_cpol, b_cpha, b_rx_valid, b_busy, b_sclk, b_mosi;
    logic        b_miso;
    logic [15:0] b_tx_data, b_rx_data;
    logic [0:0]  b_sel;
    logic [0:0]  b_cs_n;

    logic [7:0] slv_sh, slv_rx;
    logic       slv_miso;

    int         cyc, edges, seen;
    bit         cs_bad, rdy_bad;
    logic [3:0] cs0;
    logic       sclk0;

    assign a_miso = a_loop ? a_mosi : slv_miso;
    assign b_miso = b_mosi;

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(4), .CS_W(3)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .tx_data(a_tx_data), .tx_cs_sel(a_sel), .cpol(a_cpol), .cpha(a_cpha),
        .rx_valid(a_rx_valid), .rx_data(a_rx_data), .busy(a_busy), .sclk(a_sclk),
        .mosi(a_mosi), .miso(a_miso), .cs_n(a_cs_n)
    );

    spi_master_cfg #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .tx_data(b_tx_data), .tx_cs_sel(b_sel), .cpol(b_cpol), .cpha(b_cpha),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy), .sclk(b_sclk),
        .mosi(b_mosi), .miso(b_miso), .cs_n(b_cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-3 slave on cs_n[0]: drives on falling (leading) SCLK, samples on rising (trailing)
    always @(negedge a_sclk) begin
        if (!a_cs_n[0] && !a_loop) begin
            slv_miso = slv_sh[7];
            slv_sh   = {slv_sh[6:0], 1'b0};
        end
    end
    always @(posedge a_sclk) begin
        if (!a_cs_n[0] && !a_loop) slv_rx = {slv_rx[6:0], a_mosi};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_a(input logic [7:0] d, input logic [2:0] sel, input logic pol,
                           input logic pha);
        int w;
        w          = 0;
        a_tx_data  = d;
        a_sel      = sel;
        a_cpol     = pol;
        a_cpha     = pha;
        a_tx_valid = 1'b1;
        while (a_tx_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Called at the negedge before the accepting edge; returns in the rx_valid cycle
    task automatic mon_a(input bit pester);
        logic prev;
        cyc     = 0;
        edges   = 0;
        cs_bad  = 0;
        rdy_bad = 0;
        @(negedge clk);
        a_tx_valid = 1'b0;
        cs0        = a_cs_n;
        sclk0      = a_sclk;
        prev       = a_sclk;
        while (a_rx_valid !== 1'b1 && cyc < 400) begin
            if (a_cs_n !== cs0) cs_bad = 1;
            if (a_tx_ready !== 1'b0 || a_busy !== 1'b1) rdy_bad = 1;
            if (pester && cyc >= 5) begin
                a_tx_valid = 1'b1;
                a_tx_data  = 8'h0F;
                a_cpol     = ~a_cpol;
            end
            @(negedge clk);
            cyc++;
            if (a_sclk !== prev) edges++;
            prev = a_sclk;
        end
        if (cyc >= 400) cyc = -1;
    endtask

    task automatic mon_b();
        cyc = 0;
        while (b_rx_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) cyc = -1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        a_tx_valid = 1'b0; a_tx_data = '0; a_sel = '0; a_cpol = 1'b0; a_cpha = 1'b0;
        a_loop     = 1'b1;
        b_tx_valid = 1'b0; b_tx_data = '0; b_sel = '0; b_cpol = 1'b0; b_cpha = 1'b0;
        slv_sh     = '0; slv_rx = '0; slv_miso = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ready", a_tx_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_rx_valid", a_rx_valid, 0);
        chk("rst_rx_data", a_rx_data, 0);
        chk("rst_sclk", a_sclk, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_cs_n", a_cs_n, 4'hF);
        chk("rst_b_cs_n", b_cs_n, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0 loopback
        start_a(8'hA5, 3'd0, 1'b0, 1'b0);
        mon_a(0);
        chk("t1_latency", cyc, 72);
        chk("t1_edges", edges, 16);
        chk("t1_sclk_setup", sclk0, 0);
        chk("t1_cs_sel", cs0, 4'b1110);
        chk("t1_cs_steady", cs_bad, 0);
        chk("t1_busy", rdy_bad, 0);
        chk("t1_rx", a_rx_data, 8'hA5);
        chk("t1_ready_end", a_tx_ready, 1);
        chk("t1_cs_end", a_cs_n, 4'hF);
        @(negedge clk);
        chk("t1_pulse", a_rx_valid, 0);
        chk("t1_rx_hold", a_rx_data, 8'hA5);

        // Mode 3 against slave model
        a_loop = 1'b0;
        a_cpol = 1'b1;
        slv_sh = 8'h3C;
        slv_rx = 8'h00;
        repeat (2) @(negedge clk);
        chk("t2_idle_before", a_sclk, 1);
        start_a(8'hC3, 3'd0, 1'b1, 1'b1);
        mon_a(0);
        chk("t2_latency", cyc, 72);
        chk("t2_edges", edges, 16);
        chk("t2_sclk_setup", sclk0, 1);
        chk("t2_rx", a_rx_data, 8'h3C);
        chk("t2_slave_rx", slv_rx, 8'hC3);
        @(negedge clk);
        chk("t2_idle_after", a_sclk, 1);
        a_loop = 1'b1;
        a_cpol = 1'b0;
        repeat (2) @(negedge clk);

        // Chip-select decode, including an out-of-range select
        start_a(8'h96, 3'd2, 1'b0, 1'b0);
        mon_a(0);
        chk("t4_cs2", cs0, 4'b1011);
        chk("t4_cs2_steady", cs_bad, 0);
        chk("t4_rx2", a_rx_data, 8'h96);
        start_a(8'h71, 3'd5, 1'b0, 1'b0);
        mon_a(0);
        chk("t4_cs5", cs0, 4'hF);
        chk("t4_cs5_steady", cs_bad, 0);
        chk("t4_rx_pulse5", cyc, 72);
        chk("t4_rx5", a_rx_data, 8'h71);
        @(negedge clk);

        // Asynchronous reset during bit 3
        start_a(8'hE7, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        a_tx_valid = 1'b0;
        repeat (33) @(negedge clk);
        chk("t5_busy_pre", a_busy, 1);
        chk("t5_sclk_pre", a_sclk, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cs_n", a_cs_n, 4'hF);
        chk("t5_sclk", a_sclk, 0);
        chk("t5_busy", a_busy, 0);
        chk("t5_ready", a_tx_ready, 1);
        chk("t5_rx_clr", a_rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_rx_valid === 1'b1) seen++;
        end
        chk("t5_no_rx", seen, 0);
        start_a(8'h3A, 3'd0, 1'b0, 1'b0);
        mon_a(0);
        chk("t5_after_lat", cyc, 72);
        chk("t5_after_rx", a_rx_data, 8'h3A);
        @(negedge clk);

        // Pending command and toggling cpol while busy
        start_a(8'h5A, 3'd0, 1'b0, 1'b0);
        mon_a(1);
        chk("t6_latency", cyc, 72);
        chk("t6_edges", edges, 16);
        chk("t6_rx", a_rx_data, 8'h5A);
        chk("t6_busy", rdy_bad, 0);
        chk("t6_cs_steady", cs_bad, 0);
        a_cpol = 1'b0;
        a_cpha = 1'b0;
        mon_a(0);
        chk("t6_second_lat", cyc, 72);
        chk("t6_second_rx", a_rx_data, 8'h0F);
        chk("t6_second_sclk", sclk0, 0);
        @(negedge clk);

        // CLK_DIV=1, 16-bit, back-to-back
        b_tx_data  = 16'h1234;
        b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_data = 16'hFFFF;
        mon_b();
        chk("t3_latency1", cyc, 34);
        chk("t3_rx1", b_rx_data, 16'h1234);
        chk("t3_cs_gap_hi", b_cs_n, 1);
        chk("t3_ready", b_tx_ready, 1);
        @(negedge clk);
        b_tx_valid = 1'b0;
        chk("t3_cs_gap_lo", b_cs_n, 0);
        chk("t3_pulse", b_rx_valid, 0);
        mon_b();
        chk("t3_latency2", cyc, 34);
        chk("t3_rx2", b_rx_data, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
